// File: rtl/ins_commit.sv
// Commit/writeback stage: captures one execute result, performs its store over req/ack, then retires it.
// Optional INS_COMMIT_INSTRET_EN adds a 64-bit retired-instruction counter and its instret port.
module ins_commit #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter logic [31:0] PC_STEP     = 32'd4
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        commit_valid,
   output logic        commit_ready,
   input  logic        reg_w_op,
   input  logic [4:0]  reg_w_reg_idx,
   input  logic [31:0] reg_w_reg_val,
   input  logic        mem_w_op,
   input  logic [31:0] mem_w_mem_addr,
   input  logic [31:0] mem_w_mem_val,
   input  logic        reg_pc_w_op,
   input  logic [31:0] reg_pc_w_val,
   input  logic [31:0] reg_pc_val,
   output logic        rf_w_en,
   output logic [4:0]  rf_w_idx,
   output logic [31:0] rf_w_val,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   output logic        pc_w_en,
   output logic [31:0] pc_w_val,
   output logic        retire,
   output logic        err,
   output logic [1:0]  state_dbg
`ifdef INS_COMMIT_INSTRET_EN
   ,
   output logic [63:0] instret
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MEM    = 2'd1,
      RETIRE = 2'd2
   } state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        cap_rf_we_q, cap_rf_we_d;
   logic [4:0]  rf_w_idx_q, rf_w_idx_d;
   logic [31:0] rf_w_val_q, rf_w_val_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] pc_w_val_q, pc_w_val_d;
   logic        rf_w_en_q, rf_w_en_d;
   logic        pc_w_en_q, pc_w_en_d;
   logic        retire_q, retire_d;
   logic        mem_req_q, mem_req_d;
   logic        err_q, err_d;
   logic        go_retire;
`ifdef INS_COMMIT_INSTRET_EN
   logic [63:0] instret_q, instret_d;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cap_rf_we_d = cap_rf_we_q;
      rf_w_idx_d  = rf_w_idx_q;
      rf_w_val_d  = rf_w_val_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      pc_w_val_d  = pc_w_val_q;
      rf_w_en_d   = 1'b0;
      pc_w_en_d   = 1'b0;
      retire_d    = 1'b0;
      mem_req_d   = mem_req_q;
      err_d       = err_q;
      go_retire   = 1'b0;
      case (state_q)
         IDLE: begin
            if (commit_valid) begin
               // The next PC is resolved at capture so it is stable before the retire pulse.
               cap_rf_we_d = reg_w_op && (reg_w_reg_idx != 5'd0);
               rf_w_idx_d  = reg_w_reg_idx;
               rf_w_val_d  = reg_w_reg_val;
               mem_addr_d  = mem_w_mem_addr;
               mem_wdata_d = mem_w_mem_val;
               pc_w_val_d  = reg_pc_w_op ? reg_pc_w_val : reg_pc_val + PC_STEP;
               cnt_d       = 16'd0;
               if (mem_w_op) begin
                  state_d   = MEM;
                  mem_req_d = 1'b1;
               end else begin
                  go_retire = 1'b1;
               end
            end
         end
         MEM: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               go_retire = 1'b1;
            end else if (cnt_q == TIMEOUT_LAST) begin
               mem_req_d = 1'b0;
               err_d     = 1'b1;
               go_retire = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RETIRE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (go_retire) begin
         state_d   = RETIRE;
         retire_d  = 1'b1;
         pc_w_en_d = 1'b1;
         rf_w_en_d = cap_rf_we_d;
      end
`ifdef INS_COMMIT_INSTRET_EN
      instret_d = go_retire ? instret_q + 64'd1 : instret_q;
`endif
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 16'd0;
         cap_rf_we_q <= 1'b0;
         rf_w_idx_q  <= 5'd0;
         rf_w_val_q  <= 32'd0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         pc_w_val_q  <= 32'd0;
         rf_w_en_q   <= 1'b0;
         pc_w_en_q   <= 1'b0;
         retire_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         err_q       <= 1'b0;
`ifdef INS_COMMIT_INSTRET_EN
         instret_q   <= 64'd0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cap_rf_we_q <= cap_rf_we_d;
         rf_w_idx_q  <= rf_w_idx_d;
         rf_w_val_q  <= rf_w_val_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         pc_w_val_q  <= pc_w_val_d;
         rf_w_en_q   <= rf_w_en_d;
         pc_w_en_q   <= pc_w_en_d;
         retire_q    <= retire_d;
         mem_req_q   <= mem_req_d;
         err_q       <= err_d;
`ifdef INS_COMMIT_INSTRET_EN
         instret_q   <= instret_d;
`endif
      end
   end

   assign commit_ready = (state_q == IDLE);
   assign rf_w_en      = rf_w_en_q;
   assign rf_w_idx     = rf_w_idx_q;
   assign rf_w_val     = rf_w_val_q;
   assign mem_req      = mem_req_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign pc_w_en      = pc_w_en_q;
   assign pc_w_val     = pc_w_val_q;
   assign retire       = retire_q;
   assign err          = err_q;
   assign state_dbg    = state_q;
`ifdef INS_COMMIT_INSTRET_EN
   assign instret      = instret_q;
`endif

endmodule

// File: tb/tb_ins_commit.sv
// Directed plus randomized bench for ins_commit against a transaction-level reference model.
// Define INS_COMMIT_INSTRET_EN to also check the retired-instruction counter.
module tb_ins_commit;

   localparam int TO = 4;

   logic        sys_clk, sys_rst_n;
   logic        commit_valid, commit_ready;
   logic        reg_w_op;
   logic [4:0]  reg_w_reg_idx;
   logic [31:0] reg_w_reg_val;
   logic        mem_w_op;
   logic [31:0] mem_w_mem_addr, mem_w_mem_val;
   logic        reg_pc_w_op;
   logic [31:0] reg_pc_w_val, reg_pc_val;
   logic        rf_w_en;
   logic [4:0]  rf_w_idx;
   logic [31:0] rf_w_val;
   logic        mem_req, mem_ack;
   logic [31:0] mem_addr, mem_wdata;
   logic        pc_w_en;
   logic [31:0] pc_w_val;
   logic        retire, err;
   logic [1:0]  state_dbg;
`ifdef INS_COMMIT_INSTRET_EN
   logic [63:0] instret;
`endif

   int          tests = 0;
   int          failed = 0;
   logic        err_exp = 1'b0;
   longint      n_retired = 0;
   // {rf write expected, idx, value, next PC}
   logic [69:0] exp_q[$];

   ins_commit #(.MEM_TIMEOUT(TO), .PC_STEP(32'd4)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .reg_w_op(reg_w_op), .reg_w_reg_idx(reg_w_reg_idx), .reg_w_reg_val(reg_w_reg_val),
      .mem_w_op(mem_w_op), .mem_w_mem_addr(mem_w_mem_addr), .mem_w_mem_val(mem_w_mem_val),
      .reg_pc_w_op(reg_pc_w_op), .reg_pc_w_val(reg_pc_w_val), .reg_pc_val(reg_pc_val),
      .rf_w_en(rf_w_en), .rf_w_idx(rf_w_idx), .rf_w_val(rf_w_val),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .pc_w_en(pc_w_en), .pc_w_val(pc_w_val),
      .retire(retire), .err(err), .state_dbg(state_dbg)
`ifdef INS_COMMIT_INSTRET_EN
      , .instret(instret)
`endif
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic scramble();
      reg_w_op       = 1'($urandom_range(0, 1));
      reg_w_reg_idx  = 5'($urandom_range(0, 31));
      reg_w_reg_val  = $urandom();
      mem_w_op       = 1'($urandom_range(0, 1));
      mem_w_mem_addr = $urandom();
      mem_w_mem_val  = $urandom();
      reg_pc_w_op    = 1'($urandom_range(0, 1));
      reg_pc_w_val   = $urandom();
      reg_pc_val     = $urandom();
   endtask

   task automatic check_instret();
`ifdef INS_COMMIT_INSTRET_EN
      chk("instret", instret, 64'(n_retired));
`endif
   endtask

   // ack_at: MEM cycle (1-based) in which mem_ack is raised; 0 means never
   task automatic commit_txn(input logic rw_op, input logic [4:0] idx, input logic [31:0] rval,
                             input logic mw_op, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic pc_op, input logic [31:0] pcw, input logic [31:0] pc,
                             input int ack_at);
      logic [69:0] rec;
      int          waited;
      waited = 0;
      @(negedge sys_clk);
      while (commit_ready !== 1'b1 && waited < 10) begin
         @(negedge sys_clk);
         waited++;
      end
      chk("ready_before_accept", 64'(commit_ready), 64'd1);
      reg_w_op = rw_op; reg_w_reg_idx = idx; reg_w_reg_val = rval;
      mem_w_op = mw_op; mem_w_mem_addr = addr; mem_w_mem_val = wdata;
      reg_pc_w_op = pc_op; reg_pc_w_val = pcw; reg_pc_val = pc;
      commit_valid = 1'b1;
      mem_ack = 1'($urandom_range(0, 1));
      exp_q.push_back({rw_op && (idx != 5'd0), idx, rval, pc_op ? pcw : pc + 32'd4});
      @(posedge sys_clk);
      #1;
      commit_valid = 1'($urandom_range(0, 1));
      mem_ack = 1'b0;
      scramble();
      if (mw_op) begin
         for (int c = 1; c <= TO; c++) begin
            @(negedge sys_clk);
            chk("mem_req_held", 64'(mem_req), 64'd1);
            chk("mem_addr", 64'(mem_addr), 64'(addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(wdata));
            chk("ready_low_mem", 64'(commit_ready), 64'd0);
            chk("no_retire_mem", 64'(retire), 64'd0);
            if (c == ack_at) mem_ack = 1'b1;
            @(posedge sys_clk);
            #1;
            mem_ack = 1'b0;
            if (c == ack_at) break;
         end
         if (ack_at == 0) err_exp = 1'b1;
      end
      @(negedge sys_clk);
      commit_valid = 1'b0;
      rec = exp_q.pop_front();
      n_retired++;
      chk("retire", 64'(retire), 64'd1);
      chk("pc_w_en", 64'(pc_w_en), 64'd1);
      chk("pc_w_val", 64'(pc_w_val), 64'(rec[31:0]));
      chk("rf_w_en", 64'(rf_w_en), 64'(rec[69]));
      if (rec[69]) begin
         chk("rf_w_idx", 64'(rf_w_idx), 64'(rec[68:64]));
         chk("rf_w_val", 64'(rf_w_val), 64'(rec[63:32]));
      end
      chk("mem_req_retire", 64'(mem_req), 64'd0);
      chk("ready_low_retire", 64'(commit_ready), 64'd0);
      chk("err", 64'(err), 64'(err_exp));
      check_instret();
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge sys_clk);
      mem_ack = 1'b0;
      chk("retire_single", 64'(retire), 64'd0);
      chk("pc_w_en_single", 64'(pc_w_en), 64'd0);
      chk("rf_w_en_single", 64'(rf_w_en), 64'd0);
      chk("ready_after", 64'(commit_ready), 64'd1);
      chk("err_after", 64'(err), 64'(err_exp));
      check_instret();
   endtask

   initial begin
      sys_rst_n = 1'b0;
      commit_valid = 1'b0;
      mem_ack = 1'b0;
      scramble();
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      chk("rst_ready", 64'(commit_ready), 64'd1);
      chk("rst_retire", 64'(retire), 64'd0);
      chk("rst_rf_w_en", 64'(rf_w_en), 64'd0);
      chk("rst_pc_w_en", 64'(pc_w_en), 64'd0);
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_pc_w_val", 64'(pc_w_val), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      check_instret();

      commit_txn(1'b1, 5'd5, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0000_0100, 0);
      commit_txn(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0000_0104, 0);
      commit_txn(1'b0, 5'd7, 32'h0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0000_0108, 3);
      commit_txn(1'b1, 5'd1, 32'hA5A5_A5A5, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0080, 32'hFFFF_FFFC, 0);
      commit_txn(1'b1, 5'd2, 32'h5A5A_5A5A, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC, 0);
      commit_txn(1'b1, 5'd3, 32'h0000_0033, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0000_0200, 0);
      commit_txn(1'b1, 5'd4, 32'h0000_0044, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0000_0204, 0);
      commit_txn(1'b1, 5'd9, 32'h0000_0099, 1'b1, 32'h0000_4000, 32'h1111_2222, 1'b0, 32'h0, 32'h0000_0208, 1);

      for (int i = 0; i < 30; i++) begin
         logic mw;
         int   ack;
         mw  = 1'($urandom_range(0, 1));
         ack = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO - 1));
         commit_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(), mw,
                    $urandom(), $urandom(), 1'($urandom_range(0, 1)), $urandom(), $urandom(), ack);
      end

      // Reset in the middle of a store: request drops at once and nothing retires.
      @(negedge sys_clk);
      reg_w_op = 1'b1; reg_w_reg_idx = 5'd6; reg_w_reg_val = 32'h6666_6666;
      mem_w_op = 1'b1; mem_w_mem_addr = 32'h0000_5000; mem_w_mem_val = 32'h7777_8888;
      reg_pc_w_op = 1'b0; reg_pc_val = 32'h0000_0300;
      commit_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      commit_valid = 1'b0;
      @(negedge sys_clk);
      chk("mid_mem_req", 64'(mem_req), 64'd1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("async_mem_req_drop", 64'(mem_req), 64'd0);
      chk("async_retire", 64'(retire), 64'd0);
      chk("async_err_clear", 64'(err), 64'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      err_exp = 1'b0;
      n_retired = 0;
      repeat (2) begin
         @(negedge sys_clk);
         chk("post_rst_retire", 64'(retire), 64'd0);
         chk("post_rst_ready", 64'(commit_ready), 64'd1);
         chk("post_rst_mem_req", 64'(mem_req), 64'd0);
         chk("post_rst_rf_w_en", 64'(rf_w_en), 64'd0);
         check_instret();
      end

      commit_txn(1'b1, 5'd10, 32'h0000_000A, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0000_0400, 0);
      commit_txn(1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_6000, 32'h0BAD_CAFE, 1'b0, 32'h0, 32'h0000_0404, 2);
      commit_txn(1'b1, 5'd31, 32'h3131_3131, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_1000, 32'h0000_0408, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/ins_commit.md
# ins_commit

Commit/writeback stage directly downstream of the instruction execute stage. Accepts one execute result per instruction (register write, memory store, PC update) over a valid/ready handshake. Performs the store over a req/ack memory port, then retires the instruction in a single cycle by pulsing the register-file write, the PC write and a retire strobe. Sits between execute and the register file / PC register / data memory.

## Interface
- MEM_TIMEOUT, 255: max cycles mem_req waits for mem_ack before abort; legal range 1..65535.
- PC_STEP, 4: sequential PC increment when no PC write is requested.
- sys_clk  in  1  clock; all state updates on rising edge.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- commit_valid  in  1  execute result valid.
- commit_ready  out  1  block can accept a result.
- reg_w_op / reg_w_reg_idx / reg_w_reg_val  in  1/5/32  register write request.
- mem_w_op / mem_w_mem_addr / mem_w_mem_val  in  1/32/32  store request.
- reg_pc_w_op / reg_pc_w_val  in  1/32  PC redirect request.
- reg_pc_val  in  32  PC of the instruction being committed.
- rf_w_en / rf_w_idx / rf_w_val  out  1/5/32  register-file write port.
- mem_req / mem_addr / mem_wdata  out  1/32/32  data-memory store request.
- mem_ack  in  1  memory accepted the store.
- pc_w_en / pc_w_val  out  1/32  PC register write port.
- retire  out  1  one-cycle pulse per retired instruction.
- err  out  1  sticky store-timeout flag.
- instret  out  64  retired-instruction count (only with macro, see Configuration).

## Operation
- States: IDLE, MEM, RETIRE. Reset state IDLE.
- IDLE: commit_ready=1. On commit_valid=1, capture all inputs (including reg_pc_val). If captured mem_w_op=1 go MEM, else go RETIRE.
- MEM: mem_req=1, mem_addr/mem_wdata = captured store address/value, held stable. Wait counter starts at 0 on entry, +1 per cycle. mem_ack=1 → go RETIRE. Counter reaches MEM_TIMEOUT with no ack → set err, go RETIRE (store is abandoned; register/PC writes still occur).
- RETIRE (exactly one cycle): retire=1; pc_w_en=1; pc_w_val = captured reg_pc_w_op ? captured reg_pc_w_val : captured PC + PC_STEP (32-bit, wraps modulo 2^32). rf_w_en=1 only if captured reg_w_op=1 and idx≠0; rf_w_idx/rf_w_val from capture. Next state IDLE.
- commit_ready=0 in MEM and RETIRE; commit_valid there is ignored. Upstream holds payload until the accept cycle.
- mem_ack outside MEM is ignored.
- err clears only on reset.

## Timing
- Reset (async, immediate): state IDLE; commit_ready=1 once sys_rst_n high; all other outputs 0, including err, instret, mem_req, captured registers.
- Reset mid-MEM: mem_req drops asynchronously; store and instruction are lost, no retire.
- Non-store: accept at edge N; RETIRE outputs valid during cycle N+1; ready again N+2. Throughput 1 instruction per 2 cycles.
- Store: mem_req high from cycle N+1; ack sampled high at edge K; RETIRE during cycle K+1. Zero-wait ack (ack high in first MEM cycle) gives retire at N+2.
- Timeout: mem_req high for exactly MEM_TIMEOUT cycles, err rises with RETIRE cycle.
- All outputs registered; no combinational input→output path except commit_ready (state decode).

## Configuration
- INS_COMMIT_INSTRET_EN defined: 64-bit instret counter, +1 on every retire pulse, wraps to 0 after 2^64−1, reset 0; port present.
- Undefined: instret port and counter absent; all other behaviour identical.

## Test plan
- Reset then ALU result x5=0x12345678, pc=0x100, no redirect → one cycle later rf_w_en=1 idx 5 val 0x12345678, pc_w_val=0x104, retire=1.
- Write to x0 val 0xFFFFFFFF → rf_w_en stays 0, pc_w_en=1, retire=1.
- Store addr 0x2000 data 0xDEADBEEF, ack after 3 cycles → mem_req held exactly 3 cycles with stable addr/data, retire next cycle, pc_w_val=pc+4, commit_ready low throughout.
- Branch redirect reg_pc_w_val=0x80 from pc=0xFFFFFFFC, and sequential commit from pc=0xFFFFFFFC → pc_w_val=0x80, then 0x00000000 (wrap).
- MEM_TIMEOUT=4, store with no ack → mem_req 4 cycles, err=1 and stays 1, retire=1; next instruction commits normally.
- Assert sys_rst_n low mid-MEM → mem_req 0 immediately, no retire; with INS_COMMIT_INSTRET_EN, instret=0 after reset and counts 3 after three retires.
